pulse_height_capture: RTL



---
 rtl/pulse_height_capture.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pulse_height_capture.sv
// pulse_height_capture
// Qualifies pulses on a signed trapezoidal-shaper stream against a threshold,
// samples the height at the centre of the flat top, flags pile-up on
// over-long pulses and presents one height per event on a valid/ready port.
// A dead-time holdoff follows every pulse. Delivered and dropped events are
// counted with saturating counters.

module pulse_height_capture #(
  parameter int DW      = 16,
  parameter int K       = 100,
  parameter int L       = 200,
  parameter int SLACK   = 16,
  parameter int HOLDOFF = 64
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active-low
  input  logic signed [DW-1:0] din,
  input  logic signed [DW-1:0] threshold,
  input  logic                 enable,
  output logic signed [DW-1:0] ph_data,
  output logic                 ph_pileup,
  output logic                 ph_valid,
  input  logic                 ph_ready,
  output logic                 busy,
  output logic [15:0]          evt_cnt,
  output logic [15:0]          drop_cnt
);

  // Sample index of the flat-top centre, and the longest pulse still
  // considered a single event.
  localparam logic [15:0] CAP    = 16'(K + L / 2);
  localparam logic [15:0] CAP_M1 = 16'(K + L / 2 - 1);
  localparam logic [15:0] MAXW   = 16'(2 * K + L + SLACK);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RISE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t               state;
  logic [15:0]          wcnt;
  logic signed [DW-1:0] peak;
  logic                 pile;
  logic [HW-1:0]        hcnt;

  logic        above;
  logic [15:0] wcnt_inc;
  logic        emit;
  logic        slot_free;

  assign above     = din > threshold;
  assign wcnt_inc  = (wcnt == 16'hFFFF) ? wcnt : wcnt + 16'd1;
  assign emit      = (state == S_WAIT) && !above;
  assign slot_free = !ph_valid || ph_ready;

  // Pulse qualification FSM: width counting, centre capture, pile-up and holdoff.
  // NOTE: every register here is written with <= so all branches see the
  // pre-edge values of state, wcnt and hcnt, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
      peak  <= '0;
      pile  <= 1'b0;
      hcnt  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && above) begin
            state <= S_RISE;
            wcnt  <= 16'd1;
            pile  <= 1'b0;
            busy  <= 1'b1;
          end
        end

        S_RISE: begin
          if (!above) begin
            // Too short to reach the flat top: treat as noise.
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (wcnt == CAP_M1) begin
            peak  <= din;
            wcnt  <= CAP;
            state <= S_WAIT;
          end else begin
            wcnt <= wcnt_inc;
          end
        end

        S_WAIT: begin
          if (above) begin
            wcnt <= wcnt_inc;
            if (wcnt_inc > MAXW) pile <= 1'b1;
          end else begin
            state <= S_HOLD;
            hcnt  <= '0;
          end
        end

        S_HOLD: begin
          if (hcnt == HOLD_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry output slot with valid/ready handshake and event/drop counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_data   <= '0;
      ph_pileup <= 1'b0;
      ph_valid  <= 1'b0;
      evt_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (emit && slot_free) begin
        ph_data   <= peak;
        ph_pileup <= pile;
        ph_valid  <= 1'b1;
        if (evt_cnt != 16'hFFFF) evt_cnt <= evt_cnt + 16'd1;
      end else if (emit) begin
        // Slot still occupied and not being accepted: the new event is lost.
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (ph_valid && ph_ready) begin
        ph_valid <= 1'b0;
      end
    end
  end

endmodule
